// File: rtl/bmp_ram_reader_pkg.sv
// Shared constants, state and error-code types for the BMP RAM reader.
// Holds the header layout (54 bytes, field byte offsets) and the dimension check helper.
package bmp_ram_reader_pkg;

  localparam int BMP_HDR_SIZE = 54;
  localparam int HDR_SIG_OFF  = 0;
  localparam int HDR_OFF_OFF  = 10;
  localparam int HDR_W_OFF    = 18;
  localparam int HDR_H_OFF    = 22;
  localparam int HDR_BPP_OFF  = 28;

  // "BM" read little-endian from bytes 0 and 1
  localparam logic [15:0] BMP_SIG = 16'h4D42;
  localparam logic [15:0] BMP_BPP = 16'd24;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SIG  = 2'd1,
    ERR_BPP  = 2'd2,
    ERR_DIM  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CHK,
    S_FETCH,
    S_PRESENT,
    S_DONE,
    S_ERR
  } state_e;

  // Dimensions are signed 32-bit in the file; zero and negative are rejected.
  function automatic logic dim_ok(input logic [31:0] v, input int unsigned max_dim);
    return !v[31] && (v != 32'd0) && (v <= max_dim);
  endfunction

endpackage

// File: rtl/bmp_hdr_parser.sv
// Captures BMP header fields from an indexed byte stream and classifies the header.
// Fields are little-endian; err_code is a combinational verdict on the captured fields.
module bmp_hdr_parser
  import bmp_ram_reader_pkg::*;
#(
  parameter int MAX_DIM = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_vld,
  input  logic [5:0]  byte_idx,
  input  logic [7:0]  byte_data,
  output logic [31:0] offset,
  output logic [15:0] width,
  output logic [15:0] height,
  output err_code_e   err_code
);

  logic [15:0] sig;
  logic [15:0] bpp;
  logic [31:0] width_raw;
  logic [31:0] height_raw;
  logic [5:0]  rel_sig, rel_off, rel_w, rel_h, rel_bpp;

  // Indices below a field's base wrap to large values and fall outside the field.
  assign rel_sig = byte_idx - 6'(HDR_SIG_OFF);
  assign rel_off = byte_idx - 6'(HDR_OFF_OFF);
  assign rel_w   = byte_idx - 6'(HDR_W_OFF);
  assign rel_h   = byte_idx - 6'(HDR_H_OFF);
  assign rel_bpp = byte_idx - 6'(HDR_BPP_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig        <= '0;
      bpp        <= '0;
      offset     <= '0;
      width_raw  <= '0;
      height_raw <= '0;
    end else if (byte_vld) begin
      // NOTE: registers are updated with <= so every capture in this edge sees pre-edge values.
      if (rel_sig < 6'd2) sig[{rel_sig[0], 3'b000} +: 8]        <= byte_data;
      if (rel_off < 6'd4) offset[{rel_off[1:0], 3'b000} +: 8]   <= byte_data;
      if (rel_w   < 6'd4) width_raw[{rel_w[1:0], 3'b000} +: 8]  <= byte_data;
      if (rel_h   < 6'd4) height_raw[{rel_h[1:0], 3'b000} +: 8] <= byte_data;
      if (rel_bpp < 6'd2) bpp[{rel_bpp[0], 3'b000} +: 8]        <= byte_data;
    end
  end

  always_comb begin
    err_code = ERR_NONE;
    if (sig != BMP_SIG)
      err_code = ERR_SIG;
    else if (bpp != BMP_BPP)
      err_code = ERR_BPP;
    else if (!dim_ok(width_raw, MAX_DIM) || !dim_ok(height_raw, MAX_DIM))
      err_code = ERR_DIM;
  end

  assign width  = width_raw[15:0];
  assign height = height_raw[15:0];

endmodule

// File: rtl/bmp_ram_reader.sv
// Reads a BMP image out of byte RAM: header fetch and check, then a 24-bit valid/ready pixel stream.
// Define BMP_TOPDOWN_EN to emit rows top-down (pix_y=0 is the visual top row).
module bmp_ram_reader
  import bmp_ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8,
  parameter int MAX_DIM    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  RAM_rd_en,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  input  logic [BYTE_WIDTH-1:0] RAM_Q,
  output logic [15:0]           img_width,
  output logic [15:0]           img_height,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [23:0]           pix_data,
  output logic [15:0]           pix_x,
  output logic [15:0]           pix_y,
  output logic                  pix_last
);

  state_e      state, state_n;
  err_code_e   err_code_q, hdr_err;
  logic [5:0]  hdr_cnt, hdr_idx;
  logic        hdr_vld;
  logic [1:0]  bcnt;
  logic        r_live;
  logic [7:0]  b_q, g_q, r_q;
  logic [15:0] x, y;
  logic [31:0] col_off, row_base, stride;
  logic [31:0] hdr_off, w32, stride_c, row_base_c, fetch_addr;
  logic [15:0] hdr_w, hdr_h;
  logic        at_row_end, at_last;

  bmp_hdr_parser #(.MAX_DIM(MAX_DIM)) u_parser (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_vld (hdr_vld),
    .byte_idx (hdr_idx),
    .byte_data(RAM_Q[7:0]),
    .offset   (hdr_off),
    .width    (hdr_w),
    .height   (hdr_h),
    .err_code (hdr_err)
  );

  assign w32      = {16'd0, hdr_w};
  assign stride_c = ((w32 << 1) + w32 + 32'd3) & ~32'd3;
`ifdef BMP_TOPDOWN_EN
  assign row_base_c = hdr_off + ({16'd0, hdr_h} - 32'd1) * stride_c;
`else
  assign row_base_c = hdr_off;
`endif

  assign fetch_addr = row_base + col_off + {30'd0, bcnt};
  assign at_row_end = (x == img_width - 16'd1);
  assign at_last    = at_row_end && (y == img_height - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first; any path that skips an assignment would otherwise infer a latch.
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    RAM_rd_en = 1'b0;
    RAM_addr  = '0;
    pix_valid = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_HDR;
      S_HDR: begin
        busy      = 1'b1;
        RAM_rd_en = (hdr_cnt < 6'(BMP_HDR_SIZE));
        RAM_addr  = ADDR_WIDTH'(hdr_cnt);
        if (hdr_cnt == 6'(BMP_HDR_SIZE)) state_n = S_CHK;
      end
      S_CHK: begin
        busy    = 1'b1;
        state_n = (hdr_err != ERR_NONE) ? S_ERR : S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        RAM_rd_en = 1'b1;
        RAM_addr  = ADDR_WIDTH'(fetch_addr);
        if (bcnt == 2'd2) state_n = S_PRESENT;
      end
      S_PRESENT: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        if (pix_ready) state_n = at_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt    <= '0;
      hdr_idx    <= '0;
      hdr_vld    <= 1'b0;
      err_code_q <= ERR_NONE;
      stride     <= '0;
      row_base   <= '0;
      col_off    <= '0;
      x          <= '0;
      y          <= '0;
      bcnt       <= '0;
      r_live     <= 1'b0;
      b_q        <= '0;
      g_q        <= '0;
      r_q        <= '0;
      img_width  <= '0;
      img_height <= '0;
    end else begin
      // Header bytes land one cycle after their read, tagged with the address that fetched them.
      hdr_vld <= RAM_rd_en && (state == S_HDR);
      hdr_idx <= hdr_cnt;
      case (state)
        S_IDLE: if (start) begin
          hdr_cnt    <= '0;
          err_code_q <= ERR_NONE;
        end
        S_HDR: hdr_cnt <= hdr_cnt + 6'd1;
        S_CHK: begin
          if (hdr_err != ERR_NONE) begin
            err_code_q <= hdr_err;
          end else begin
            stride     <= stride_c;
            row_base   <= row_base_c;
            col_off    <= '0;
            x          <= '0;
            y          <= '0;
            bcnt       <= '0;
            img_width  <= hdr_w;
            img_height <= hdr_h;
          end
        end
        S_FETCH: begin
          if (bcnt == 2'd1) b_q <= RAM_Q[7:0];
          if (bcnt == 2'd2) begin
            g_q    <= RAM_Q[7:0];
            r_live <= 1'b1;
            bcnt   <= '0;
          end else begin
            bcnt <= bcnt + 2'd1;
          end
        end
        S_PRESENT: begin
          // Red arrives on the first PRESENT cycle; it is shown straight from RAM_Q and held here.
          if (r_live) begin
            r_q    <= RAM_Q[7:0];
            r_live <= 1'b0;
          end
          if (pix_ready) begin
            if (at_row_end) begin
              x       <= '0;
              col_off <= '0;
              y       <= y + 16'd1;
`ifdef BMP_TOPDOWN_EN
              row_base <= row_base - stride;
`else
              row_base <= row_base + stride;
`endif
            end else begin
              x       <= x + 16'd1;
              col_off <= col_off + 32'd3;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err_code = err_code_q;
  assign pix_data = {(r_live ? RAM_Q[7:0] : r_q), g_q, b_q};
  assign pix_x    = x;
  assign pix_y    = y;
  assign pix_last = pix_valid && at_last;

endmodule
